// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch -- instruction fetch unit for the NPC core.
//
// Holds the PC, issues one 32-bit read at a time to the instruction-memory
// port (valid/ready request, valid-only response) and hands each fetched word
// with its PC to decode over a valid/ready handshake. Accepts redirects from
// execute and a halt from the ebreak path. No prefetch: at most one read is
// outstanding.
//
// Optional feature macro: IFU_MISALIGN_CHECK_EN
//   defined   : a redirect to a non word-aligned target parks the unit in
//               FAULT (misalign_fault=1, inst_pc = faulting target).
//   undefined : redirect_pc[1:0] is forced to 2'b00, misalign_fault is 0.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   mem_req_valid/ready/addr          instruction read request
//   mem_resp_valid/data               read response (never back-pressured)
//   inst_valid/ready, inst, inst_pc   instruction to decode
//   redirect_valid, redirect_pc       branch/jump redirect from execute
//   halt                              stop fetching (ebreak retired)
//   misalign_fault                    misaligned redirect target seen
// ---------------------------------------------------------------------------
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        misalign_fault
);

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_OUT   = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        drop_q, drop_d;       // a read is in flight whose data is stale
  logic        hpend_q, hpend_d;     // halt seen while waiting on a read

  logic [31:0] rd_pc;                // effective redirect target
  logic        rd_fault;             // redirect target is misaligned

`ifdef IFU_MISALIGN_CHECK_EN
  assign rd_pc    = redirect_pc;
  assign rd_fault = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  logic unused_rd_lsb;
  assign unused_rd_lsb = ^redirect_pc[1:0];
  assign rd_pc         = {redirect_pc[31:2], 2'b00};
  assign rd_fault      = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  logic stop;
  assign stop = hpend_q || halt;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    drop_d    = drop_q;
    hpend_d   = hpend_q;

    case (state_q)
      S_REQ: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (redirect_valid) begin
          // Redirect wins over an accept; the request was never offered.
          if (rd_fault) begin
            state_d   = S_FAULT;
            inst_pc_d = redirect_pc;
          end else begin
            pc_d = rd_pc;
          end
        end else if (mem_req_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (halt) hpend_d = 1'b1;
        if (rd_fault) begin
          // Outstanding response will land in FAULT and be ignored there.
          state_d   = S_FAULT;
          inst_pc_d = redirect_pc;
          drop_d    = 1'b0;
          hpend_d   = 1'b0;
        end else if (mem_resp_valid) begin
          drop_d  = 1'b0;
          hpend_d = 1'b0;
          if (redirect_valid) pc_d = rd_pc;
          if (redirect_valid || drop_q || stop) begin
            state_d = stop ? S_HALT : S_REQ;
          end else begin
            inst_d    = mem_resp_data;
            inst_pc_d = pc_q;
            state_d   = S_OUT;
          end
        end else if (redirect_valid) begin
          // Read still in flight: remember to throw its data away.
          pc_d   = rd_pc;
          drop_d = 1'b1;
        end
      end

      S_OUT: begin
        if (redirect_valid) begin
          if (rd_fault) begin
            state_d   = S_FAULT;
            inst_pc_d = redirect_pc;
          end else begin
            pc_d    = rd_pc;
            state_d = S_REQ;
          end
        end else if (inst_ready) begin
          pc_d    = pc_q + PC_STEP;
          state_d = halt ? S_HALT : S_REQ;
        end
      end

      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_REQ;
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= 32'd0;
      inst_pc_q <= 32'd0;
      drop_q    <= 1'b0;
      hpend_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      drop_q    <= drop_d;
      hpend_q   <= hpend_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // The request is withdrawn in a cycle where halt or a redirect takes
  // precedence, so memory never sees a handshake the unit does not track.
  assign mem_req_valid = !rst && (state_q == S_REQ) && !halt && !redirect_valid;
  assign mem_req_addr  = pc_q;
  assign inst_valid    = !rst && (state_q == S_OUT) && !redirect_valid;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;

`ifdef IFU_MISALIGN_CHECK_EN
  assign misalign_fault = !rst && (state_q == S_FAULT);
`else
  assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a cycle-by-cycle vector table for the main
// fetch/stall/redirect/halt flow, then hand-written corner sequences.
module tb_ifu_fetch;

  localparam logic [31:0] A = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        misalign_fault;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .misalign_fault (misalign_fault)
  );

  typedef struct {
    logic        rst, rdy, rv;
    logic [31:0] rdata;
    logic        irdy, redir;
    logic [31:0] rpc;
    logic        hlt;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst, e_ipc;
    logic        chk;   // also compare addr/inst/inst_pc
  } vec_t;

  vec_t tv[$];

  function automatic void add(input logic r, rdy, rv, input logic [31:0] rd,
                              input logic ir, rdv, input logic [31:0] rp,
                              input logic h, erv, input logic [31:0] ea,
                              input logic eiv, input logic [31:0] ei, eip,
                              input logic c);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rv = rv; v.rdata = rd; v.irdy = ir;
    v.redir = rdv; v.rpc = rp; v.hlt = h; v.e_rv = erv; v.e_addr = ea;
    v.e_iv = eiv; v.e_inst = ei; v.e_ipc = eip; v.chk = c;
    tv.push_back(v);
  endfunction

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic r, rdy, rv, input logic [31:0] rd,
                       input logic ir, rdv, input logic [31:0] rp,
                       input logic h);
    @(negedge clk);
    rst = r; mem_req_ready = rdy; mem_resp_valid = rv; mem_resp_data = rd;
    inst_ready = ir; redirect_valid = rdv; redirect_pc = rp; halt = h;
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_data = '0; inst_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; halt = 1'b0;

    // ---------------- vector table ----------------
    //  rst rdy rv rdata           ir rd rpc       h  erv eaddr    eiv einst            eipc     chk
    add(1, 0, 0, 32'h0,          0, 0, 32'h0,    0, 0, 32'h0,   0, 32'h0,          32'h0,   0);
    add(1, 0, 0, 32'h0,          0, 0, 32'h0,    0, 0, A,       0, 32'h0,          32'h0,   1);
    add(0, 1, 0, 32'h0,          0, 0, 32'h0,    0, 1, A,       0, 32'h0,          32'h0,   1);
    add(0, 0, 1, 32'h13,         0, 0, 32'h0,    0, 0, 32'h0,   0, 32'h0,          32'h0,   0);
    add(0, 0, 0, 32'h0,          1, 0, 32'h0,    0, 0, A,       1, 32'h13,         A,       1);
    add(0, 1, 0, 32'h0,          0, 0, 32'h0,    0, 1, A+4,     0, 32'h13,         A,       1);
    add(0, 0, 1, 32'h93,         0, 0, 32'h0,    0, 0, 32'h0,   0, 32'h0,          32'h0,   0);
    add(0, 0, 0, 32'h0,          1, 0, 32'h0,    0, 0, A+4,     1, 32'h93,         A+4,     1);
    add(0, 1, 0, 32'h0,          0, 0, 32'h0,    0, 1, A+8,     0, 32'h93,         A+4,     1);
    add(0, 0, 1, 32'h00100093,   0, 0, 32'h0,    0, 0, 32'h0,   0, 32'h0,          32'h0,   0);
    // decode stalls 5 cycles: word held, no new request even with ready high
    for (int k = 0; k < 5; k++)
      add(0, 1, 0, 32'h0,        0, 0, 32'h0,    0, 0, A+8,     1, 32'h00100093,   A+8,     1);
    add(0, 0, 0, 32'h0,          1, 0, 32'h0,    0, 0, A+8,     1, 32'h00100093,   A+8,     1);
    add(0, 1, 0, 32'h0,          0, 0, 32'h0,    0, 1, A+12,    0, 32'h00100093,   A+8,     1);
    // redirect while waiting; stale response two cycles later is dropped
    add(0, 0, 0, 32'h0,          0, 1, A+256,    0, 0, 32'h0,   0, 32'h0,          32'h0,   0);
    add(0, 0, 0, 32'h0,          0, 0, 32'h0,    0, 0, A+256,   0, 32'h00100093,   A+8,     1);
    add(0, 0, 1, 32'hDEADBEEF,   0, 0, 32'h0,    0, 0, A+256,   0, 32'h00100093,   A+8,     1);
    add(0, 1, 0, 32'h0,          0, 0, 32'h0,    0, 1, A+256,   0, 32'h00100093,   A+8,     1);
    add(0, 0, 1, 32'h11111111,   0, 0, 32'h0,    0, 0, 32'h0,   0, 32'h0,          32'h0,   0);
    // redirect beats inst_ready in OUT
    add(0, 0, 0, 32'h0,          1, 1, A+512,    0, 0, A+256,   0, 32'h11111111,   A+256,   1);
    add(0, 1, 0, 32'h0,          0, 0, 32'h0,    0, 1, A+512,   0, 32'h11111111,   A+256,   1);
    // redirect coincident with response
    add(0, 0, 1, 32'h22222222,   0, 1, A+768,    0, 0, 32'h0,   0, 32'h0,          32'h0,   0);
    add(0, 0, 0, 32'h0,          0, 0, 32'h0,    0, 1, A+768,   0, 32'h11111111,   A+256,   1);
    add(0, 1, 0, 32'h0,          0, 0, 32'h0,    0, 1, A+768,   0, 32'h0,          32'h0,   0);
    add(0, 0, 1, 32'h00100073,   0, 0, 32'h0,    0, 0, 32'h0,   0, 32'h0,          32'h0,   0);
    // ebreak consumed with halt high
    add(0, 0, 0, 32'h0,          1, 0, 32'h0,    1, 0, A+768,   1, 32'h00100073,   A+768,   1);

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].rdy, tv[i].rv, tv[i].rdata, tv[i].irdy,
            tv[i].redir, tv[i].rpc, tv[i].hlt);
      chk($sformatf("v%0d req_valid", i), {31'd0, mem_req_valid}, {31'd0, tv[i].e_rv});
      chk($sformatf("v%0d inst_valid", i), {31'd0, inst_valid}, {31'd0, tv[i].e_iv});
      chk($sformatf("v%0d misalign", i), {31'd0, misalign_fault}, 32'd0);
      if (tv[i].chk) begin
        chk($sformatf("v%0d req_addr", i), mem_req_addr, tv[i].e_addr);
        chk($sformatf("v%0d inst", i), inst, tv[i].e_inst);
        chk($sformatf("v%0d inst_pc", i), inst_pc, tv[i].e_ipc);
      end
    end

    // ---------------- halted: stays quiet for 20 cycles ----------------
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, 0, 32'h0, 1, 0, 32'h0, 0);
      chk($sformatf("halt%0d req_valid", k), {31'd0, mem_req_valid}, 32'd0);
      chk($sformatf("halt%0d inst_valid", k), {31'd0, inst_valid}, 32'd0);
    end
    drive(1, 1, 0, 32'h0, 0, 0, 32'h0, 0);
    drive(0, 1, 0, 32'h0, 0, 0, 32'h0, 0);
    chk("restart req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("restart req_addr", mem_req_addr, A);

    // ---------------- halt sampled in REQ ----------------
    drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    drive(0, 1, 0, 32'h0, 0, 0, 32'h0, 1);
    chk("halt_req no request", {31'd0, mem_req_valid}, 32'd0);
    drive(0, 1, 0, 32'h0, 0, 0, 32'h0, 0);
    chk("halt_req parked", {31'd0, mem_req_valid}, 32'd0);

    // ---------------- halt sampled in WAIT ----------------
    drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    drive(0, 1, 0, 32'h0, 0, 0, 32'h0, 0);
    chk("halt_wait req", {31'd0, mem_req_valid}, 32'd1);
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 1);
    drive(0, 0, 1, 32'hAAAA5555, 0, 0, 32'h0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 32'h0, 1, 0, 32'h0, 0);
      chk($sformatf("halt_wait%0d req", k), {31'd0, mem_req_valid}, 32'd0);
      chk($sformatf("halt_wait%0d iv", k), {31'd0, inst_valid}, 32'd0);
    end

    // ---------------- PC wrap at the top of the address space ----------------
    drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    drive(0, 1, 0, 32'h0, 0, 1, 32'hFFFF_FFFC, 0);
    chk("wrap redirect withdraws req", {31'd0, mem_req_valid}, 32'd0);
    drive(0, 1, 0, 32'h0, 0, 0, 32'h0, 0);
    chk("wrap req_addr", mem_req_addr, 32'hFFFF_FFFC);
    drive(0, 0, 1, 32'h13, 0, 0, 32'h0, 0);
    drive(0, 0, 0, 32'h0, 1, 0, 32'h0, 0);
    chk("wrap inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("wrap inst_pc", inst_pc, 32'hFFFF_FFFC);
    drive(0, 1, 0, 32'h0, 0, 0, 32'h0, 0);
    chk("wrap next addr", mem_req_addr, 32'h0);
    chk("wrap next req", {31'd0, mem_req_valid}, 32'd1);

    // ---------------- misaligned redirect ----------------
    drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    drive(0, 1, 0, 32'h0, 0, 1, A+32'h102, 0);
    chk("mis redirect withdraws req", {31'd0, mem_req_valid}, 32'd0);
    drive(0, 1, 0, 32'h0, 0, 0, 32'h0, 0);
`ifdef IFU_MISALIGN_CHECK_EN
    chk("mis fault", {31'd0, misalign_fault}, 32'd1);
    chk("mis no req", {31'd0, mem_req_valid}, 32'd0);
    chk("mis inst_pc", inst_pc, A+32'h102);
    drive(0, 1, 0, 32'h0, 1, 0, 32'h0, 0);
    chk("mis stays faulted", {31'd0, misalign_fault}, 32'd1);
`else
    chk("mis no fault", {31'd0, misalign_fault}, 32'd0);
    chk("mis req", {31'd0, mem_req_valid}, 32'd1);
    chk("mis aligned addr", mem_req_addr, A+32'h100);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit for the NPC core; sits directly upstream of the decode stage.
- Holds the PC and issues 32-bit instruction reads to the instruction-memory port over a valid/ready request plus valid-only response.
- Presents each fetched word, with its PC, to decode over a valid/ready handshake.
- Accepts redirects from execute (branch/jump) and a halt from the ebreak path.

Parameters:
RESET_PC, 32'h80000000, PC loaded on reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
mem_req_valid  output  1  instruction read request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  32  read address (current PC)
mem_resp_valid  input  1  read data valid; memory never back-pressures responses
mem_resp_data  input  32  instruction word
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode consumes instruction
inst  output  32  instruction word to decode
inst_pc  output  32  PC of inst
redirect_valid  input  1  redirect request from execute
redirect_pc  input  32  redirect target
halt  input  1  stop fetching (ebreak retired)
misalign_fault  output  1  redirect target misaligned (see optional feature)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (`rst`=1 at a rising edge):
  - state<=REQ, pc<=RESET_PC, inst<=0, inst_pc<=0, drop<=0.
  - Outputs while `rst` is high: mem_req_valid=0, inst_valid=0, misalign_fault=0.
  - Reset mid-transaction abandons any outstanding read. A response arriving after reset is ignored because the unit is in REQ, not WAIT.
- States: REQ, WAIT, OUT, HALT (plus FAULT with the macro).
- REQ:
  - mem_req_valid=1, mem_req_addr=pc.
  - mem_req_valid&&mem_req_ready -> WAIT.
  - redirect_valid -> pc<=redirect_pc, stay in REQ; the request is not counted as accepted even if ready was high. Redirect wins.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid with drop=0 -> inst<=mem_resp_data, inst_pc<=pc, go to OUT.
  - On mem_resp_valid with drop=1 -> discard, drop<=0, go to REQ.
  - redirect_valid -> pc<=redirect_pc, drop<=1.
  - redirect_valid and mem_resp_valid in the same cycle -> response discarded, pc<=redirect_pc, drop<=0, go to REQ.
- OUT:
  - inst_valid = (state==OUT) && !redirect_valid.
  - inst and inst_pc are held stable until the handshake completes.
  - inst_valid&&inst_ready -> pc<=pc+PC_STEP (32-bit wrap, 32'hFFFFFFFC+4=0); next state is HALT if halt is high that cycle, else REQ.
  - redirect_valid -> pc<=redirect_pc, go to REQ. Redirect has priority over inst_ready.
- halt:
  - Sampled in REQ: go to HALT without issuing a request.
  - In WAIT: finish and discard the response, then go to HALT.
  - HALT: all valids 0; only rst exits.
- Latency: minimum 3 cycles per instruction (request accept, response, decode handshake). Response arrives no earlier than the cycle after accept.
- Throughput: at most one outstanding read; no prefetch.

Optional Feature:
- Macro IFU_MISALIGN_CHECK_EN.
- Defined:
  - redirect_valid with redirect_pc[1:0]!=0 -> go to FAULT.
  - FAULT: misalign_fault=1, no requests, inst_valid=0, inst_pc holds the faulting target; only rst exits.
  - In WAIT, the pending response is discarded.
- Not defined: redirect_pc[1:0] is forced to 2'b00, and misalign_fault is tied to 0.

Test Plan:
- Reset, mem_req_ready=1, 1-cycle response latency, inst_ready=1 -> addresses 0x80000000, 0x80000004, 0x80000008 issued; inst_pc matches each; inst_valid pulses every 3 cycles.
- inst_ready held low 5 cycles in OUT, with data 0x00100093 -> inst/inst_pc stable and no new mem_req_valid until ready rises; then next addr = +4.
- Redirect to 0x80000100 while in WAIT, response 0xDEADBEEF arrives 2 cycles later -> response dropped, inst_valid stays 0, next request addr 0x80000100.
- redirect_valid and inst_ready high together in OUT -> no handshake counted, next addr = redirect_pc. Also redirect coincident with mem_resp_valid -> discarded, next addr = redirect_pc.
- halt asserted with ebreak word 0x00100073 in OUT and inst_ready=1 -> handshake completes, mem_req_valid stays 0 for 20 cycles; rst restarts at RESET_PC.
- With IFU_MISALIGN_CHECK_EN, redirect_pc=0x80000102 -> misalign_fault=1 next cycle, no requests. Without the macro -> fetch addr 0x80000100.
